operand_fetch_stage: RTL

//  Register-read stage between the decoder and EX. Drives register-file read addresses, applies

---
 rtl/operand_fetch_stage_if.sv | 55 +++++
 rtl/operand_fetch_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch stage bus.
// Groups the decoder handshake, register-file read port, writeback bypass/retire
// inputs, pipeline control (flush / ex_hold) and the ID/EX register outputs.
//   master : the environment (decoder, register file, WB, EX control)
//   slave  : operand_fetch_stage
interface operand_fetch_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CTRL_W = 9
);
    // Decoder side
    logic              id_valid;
    logic [ADDR_W-1:0] id_src1;
    logic [ADDR_W-1:0] id_src2;
    logic              id_use1;
    logic              id_use2;
    logic [ADDR_W-1:0] id_dest;
    logic              id_wb_en;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_ready;
    // Register file read port
    logic [ADDR_W-1:0] rf_src1;
    logic [ADDR_W-1:0] rf_src2;
    logic [DATA_W-1:0] rf_reg1;
    logic [DATA_W-1:0] rf_reg2;
    // Writeback
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    // Pipeline control
    logic              flush;
    logic              ex_hold;
    // ID/EX register
    logic              ex_valid;
    logic [DATA_W-1:0] ex_val1;
    logic [DATA_W-1:0] ex_val2;
    logic [ADDR_W-1:0] ex_dest;
    logic              ex_wb_en;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              sb_err;

    modport master (
        output id_valid, id_src1, id_src2, id_use1, id_use2, id_dest, id_wb_en, id_ctrl,
        output rf_reg1, rf_reg2, wb_en, wb_dest, wb_value, flush, ex_hold,
        input  id_ready, rf_src1, rf_src2,
        input  ex_valid, ex_val1, ex_val2, ex_dest, ex_wb_en, ex_ctrl, sb_err
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dest, id_wb_en, id_ctrl,
        input  rf_reg1, rf_reg2, wb_en, wb_dest, wb_value, flush, ex_hold,
        output id_ready, rf_src1, rf_src2,
        output ex_valid, ex_val1, ex_val2, ex_dest, ex_wb_en, ex_ctrl, sb_err
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Register-read stage between decoder and EX.
// Drives register-file read addresses, bypasses a same-cycle writeback into the
// operands, stalls on RAW hazards using a per-register pending-write counter, and
// holds the ID/EX pipeline register.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : operand_fetch_stage_if.slave (decoder, RF, WB, flush/hold, ID/EX outputs)
module operand_fetch_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CTRL_W   = 9,
    parameter int unsigned CNT_W    = 2
) (
    input logic                  clk,
    input logic                  rst,
    operand_fetch_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt_d [NUM_REGS];
    logic                r_sb_err;
    logic                w_err_d;

    logic                r_ex_valid;
    logic [DATA_W-1:0]   r_ex_val1;
    logic [DATA_W-1:0]   r_ex_val2;
    logic [ADDR_W-1:0]   r_ex_dest;
    logic                r_ex_wb_en;
    logic [CTRL_W-1:0]   r_ex_ctrl;

    logic                w_hit1, w_hit2;
    logic [DATA_W-1:0]   w_op1, w_op2;
    logic [CNT_W-1:0]    w_cnt1, w_cnt2;
    logic                w_haz1, w_haz2;
    logic                w_ready, w_issue;
    logic [NUM_REGS-1:0] w_inc, w_dec;

    // Bypass: a result retiring this cycle is newer than the register file contents.
    assign w_hit1 = bus.wb_en && (bus.wb_dest == bus.id_src1);
    assign w_hit2 = bus.wb_en && (bus.wb_dest == bus.id_src2);
    assign w_op1  = w_hit1 ? bus.wb_value : bus.rf_reg1;
    assign w_op2  = w_hit2 ? bus.wb_value : bus.rf_reg2;

    // A pending write is harmless only if it is the last one and is retiring right now.
    assign w_cnt1 = r_cnt[bus.id_src1];
    assign w_cnt2 = r_cnt[bus.id_src2];
    assign w_haz1 = bus.id_use1 && (w_cnt1 != '0) && !(w_hit1 && (w_cnt1 == CntOne));
    assign w_haz2 = bus.id_use2 && (w_cnt2 != '0) && !(w_hit2 && (w_cnt2 == CntOne));

    assign w_ready = !bus.ex_hold && !bus.flush && !w_haz1 && !w_haz2;
    assign w_issue = bus.id_valid && w_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue && bus.id_wb_en) begin
            w_inc[bus.id_dest] = 1'b1;
        end
        if (bus.wb_en) begin
            w_dec[bus.wb_dest] = 1'b1;
        end
    end

    // Counter next state; inc and dec on the same register cancel out.
    always_comb begin
        w_err_d = r_sb_err;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_d[i] = r_cnt[i];
            if (w_inc[i] && !w_dec[i]) begin
                if (r_cnt[i] == CntMax) begin
                    w_err_d = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CntOne;
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_cnt[i] == '0) begin
                    w_err_d = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] - CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_sb_err <= w_err_d;
        end
    end

    // ID/EX register: hold beats flush beats issue; anything else is a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
            r_ex_val1  <= '0;
            r_ex_val2  <= '0;
            r_ex_dest  <= '0;
            r_ex_wb_en <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (!bus.ex_hold) begin
            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_ex_val1  <= w_op1;
                r_ex_val2  <= w_op2;
                r_ex_dest  <= bus.id_dest;
                r_ex_wb_en <= bus.id_wb_en;
                r_ex_ctrl  <= bus.id_ctrl;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_val1  <= '0;
                r_ex_val2  <= '0;
                r_ex_dest  <= '0;
                r_ex_wb_en <= 1'b0;
                r_ex_ctrl  <= '0;
            end
        end
    end

    assign bus.id_ready = w_ready;
    assign bus.rf_src1  = bus.id_src1;
    assign bus.rf_src2  = bus.id_src2;
    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_val1  = r_ex_val1;
    assign bus.ex_val2  = r_ex_val2;
    assign bus.ex_dest  = r_ex_dest;
    assign bus.ex_wb_en = r_ex_wb_en;
    assign bus.ex_ctrl  = r_ex_ctrl;
    assign bus.sb_err   = r_sb_err;

endmodule
